// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

   localparam int          WORD_W           = 32;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered fetch result: the instruction word and the address it came from.
   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
   } fetch_entry_t;

   // Fetch targets are always word aligned; low address bits are discarded.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries between the memory response and decode.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: none internally; the producer must never push into a full buffer.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push = push & ~flush & ~rst;
   assign do_pop  = pop & ~flush & ~rst & (count != '0);
   assign head    = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The issue logic upstream must keep occupancy bounded; an overflow is a design bug.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads, buffers responses, hands {instr,pc,pc+4} to decode.
// Latency: request in cycle N, out_valid in N+2; redirect target appears at T+3.
// Backpressure: out_ready low fills the buffer, then imem_req stops until space frees.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      fetch_pc;
   logic [31:0]      pc_shadow;
   logic             inflight;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   logic             pop;
   logic             push;
   fetch_entry_t     push_data;
   fetch_entry_t     head;

   // Occupancy counts the outstanding response as already buffered, so a push never overflows.
   assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};

   assign out_valid = ~rst & ~redirect_valid & (count != '0);
   assign pop       = out_valid & out_ready;
   assign imem_req  = ~rst & ~redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));
   assign imem_addr = fetch_pc;

   // A response is dropped when a redirect lands in the same cycle it returns.
   assign push      = inflight & ~redirect_valid & ~rst;
   assign push_data = '{instr: imem_rdata, pc: pc_shadow};

   // Head fields are forced to zero while reset is held so nothing stale leaks out.
   assign out_instr = rst ? 32'h0 : head.instr;
   assign out_pc    = rst ? 32'h0 : head.pc;
   assign out_pc4   = rst ? 32'h0 : head.pc + 32'(INSTR_BYTES);

   // Fetch PC, in-flight flag and the address shadow of the outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         inflight  <= 1'b0;
         pc_shadow <= 32'h0;
      end else if (redirect_valid) begin
         fetch_pc  <= word_align(redirect_pc);
         inflight  <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            pc_shadow <= fetch_pc;
            fetch_pc  <= fetch_pc + 32'(INSTR_BYTES);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against hand-computed vectors and a PC model.
// Memory returns word[i] = i, so every instruction equals its pc >> 2.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;

   logic        w_rst;
   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [31:0] w_out_instr;
   logic [31:0] w_out_pc;
   logic [31:0] w_out_pc4;

   int n_chk;
   int n_pass;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc4        (out_pc4)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
      .clk            (clk),
      .rst            (w_rst),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .imem_req       (w_imem_req),
      .imem_addr      (w_imem_addr),
      .imem_rdata     (w_imem_rdata),
      .out_valid      (w_out_valid),
      .out_ready      (w_out_ready),
      .out_instr      (w_out_instr),
      .out_pc         (w_out_pc),
      .out_pc4        (w_out_pc4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read instruction memories, word[i] = i.
   always @(posedge clk) begin
      if (imem_req)   imem_rdata   <= {2'b00, imem_addr[31:2]};
      if (w_imem_req) w_imem_rdata <= {2'b00, w_imem_addr[31:2]};
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        rst;
      logic        rdv;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        ov;
      logic [31:0] pc;
      int          cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t v;

   task automatic add(input logic r, input logic d, input logic [31:0] rp, input logic y,
                      input logic q, input logic [31:0] a, input logic o,
                      input logic [31:0] p, input int c);
      vec_t t;
      t = '{r, d, rp, y, q, a, o, p, c};
      tbl.push_back(t);
   endtask

   initial begin
      logic [31:0] exp_pc;
      int          pops;
      int          waited;

      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      out_ready = 1'b1;
      w_rst = 1'b1;
      w_out_ready = 1'b1;

      //   rst rdv rpc      rdy | req addr     ov  pc      cnt
      add(1, 0, 32'h0,   1,   0, 32'h0,   0, 32'h0,   0);  // startup stream
      add(0, 0, 32'h0,   1,   1, 32'h0,   0, 32'h0,   0);
      add(0, 0, 32'h0,   1,   1, 32'h4,   0, 32'h0,   0);
      add(0, 0, 32'h0,   1,   1, 32'h8,   1, 32'h0,   1);
      add(0, 0, 32'h0,   1,   1, 32'hC,   1, 32'h4,   1);
      add(0, 0, 32'h0,   1,   1, 32'h10,  1, 32'h8,   1);
      add(1, 1, 32'h500, 0,   0, 32'h0,   0, 32'h0,   0);  // reset beats redirect
      add(0, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   0);  // stall from start
      add(0, 0, 32'h0,   0,   1, 32'h4,   0, 32'h0,   0);
      add(0, 0, 32'h0,   0,   0, 32'h0,   1, 32'h0,   1);
      add(0, 0, 32'h0,   0,   0, 32'h0,   1, 32'h0,   2);
      add(0, 0, 32'h0,   0,   0, 32'h0,   1, 32'h0,   2);
      add(0, 0, 32'h0,   0,   0, 32'h0,   1, 32'h0,   2);
      add(0, 0, 32'h0,   0,   0, 32'h0,   1, 32'h0,   2);
      add(0, 0, 32'h0,   1,   1, 32'h8,   1, 32'h0,   2);  // release: no gap
      add(0, 0, 32'h0,   1,   1, 32'hC,   1, 32'h4,   1);
      add(0, 0, 32'h0,   1,   1, 32'h10,  1, 32'h8,   1);
      add(0, 1, 32'h103, 1,   0, 32'h0,   0, 32'h0,   1);  // redirect with work buffered
      add(0, 0, 32'h0,   1,   1, 32'h100, 0, 32'h0,   0);
      add(0, 0, 32'h0,   1,   1, 32'h104, 0, 32'h0,   0);
      add(0, 0, 32'h0,   1,   1, 32'h108, 1, 32'h100, 1);
      add(0, 0, 32'h0,   1,   1, 32'h10C, 1, 32'h104, 1);
      add(0, 1, 32'h200, 1,   0, 32'h0,   0, 32'h0,   1);  // back-to-back redirects
      add(0, 1, 32'h301, 1,   0, 32'h0,   0, 32'h0,   0);
      add(0, 0, 32'h0,   1,   1, 32'h300, 0, 32'h0,   0);
      add(0, 0, 32'h0,   1,   1, 32'h304, 0, 32'h0,   0);
      add(0, 0, 32'h0,   1,   1, 32'h308, 1, 32'h300, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(negedge clk);
         rst = v.rst;
         redirect_valid = v.rdv;
         redirect_pc = v.rpc;
         out_ready = v.rdy;
         #1;
         chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, v.req});
         if (v.req) chk($sformatf("row%0d imem_addr", i), imem_addr, v.addr);
         chk($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, v.ov});
         if (v.rst) begin
            chk($sformatf("row%0d rst_instr", i), out_instr, 32'h0);
            chk($sformatf("row%0d rst_pc", i), out_pc, 32'h0);
            chk($sformatf("row%0d rst_pc4", i), out_pc4, 32'h0);
         end else begin
            chk($sformatf("row%0d count", i), 32'(dut.u_fifo.count), 32'(v.cnt));
         end
         if (v.ov) begin
            chk($sformatf("row%0d out_pc", i), out_pc, v.pc);
            chk($sformatf("row%0d out_instr", i), out_instr, {2'b00, v.pc[31:2]});
            chk($sformatf("row%0d out_pc4", i), out_pc4, v.pc + 32'd4);
         end
      end

      // Mid-stream reset with the buffer full.
      @(negedge clk);
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      waited = 0;
      while (dut.u_fifo.count != 2 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      #1;
      chk("fill_count", 32'(dut.u_fifo.count), 32'd2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_valid_held", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_count", 32'(dut.u_fifo.count), 32'd0);
      chk("midrst_addr", imem_addr, 32'h0);
      chk("midrst_req", {31'b0, imem_req}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("midrst_first_valid", {31'b0, out_valid}, 32'd1);
      chk("midrst_first_pc", out_pc, 32'h0);

      // Address wrap from a high reset PC.
      @(negedge clk);
      w_rst = 1'b0;
      #1;
      chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFF8);
      chk("wrap_req0", {31'b0, w_imem_req}, 32'd1);
      @(negedge clk);
      #1;
      chk("wrap_addr1", w_imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      #1;
      chk("wrap_addr2", w_imem_addr, 32'h0);
      chk("wrap_pc0", w_out_pc, 32'hFFFF_FFF8);
      chk("wrap_pc4_0", w_out_pc4, 32'hFFFF_FFFC);
      @(negedge clk);
      #1;
      chk("wrap_pc1", w_out_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4_1", w_out_pc4, 32'h0);
      chk("wrap_instr1", w_out_instr, 32'h3FFF_FFFF);
      @(negedge clk);
      #1;
      chk("wrap_pc2", w_out_pc, 32'h0);
      chk("wrap_valid2", {31'b0, w_out_valid}, 32'd1);

      // Random backpressure and redirects against a next-expected-PC model.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_pc = 32'h0;
      pops = 0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 1) == 1);
         redirect_valid = ($urandom_range(0, 99) < 5);
         redirect_pc = $urandom;
         #1;
         if (out_valid && out_ready) begin
            chk("rand_pc", out_pc, exp_pc);
            chk("rand_instr", out_instr, {2'b00, exp_pc[31:2]});
            chk("rand_pc4", out_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         if (redirect_valid) begin
            chk("rand_redirect_quiet", {30'b0, out_valid, imem_req}, 32'd0);
            exp_pc = {redirect_pc[31:2], 2'b00};
         end
      end
      chk("rand_progress", {31'b0, pops > 2000}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
